cordic_phase_sched: RTL

CORDIC_PHASE_SCHED -- requirements
Module: cordic_phase_sched

---
 rtl/cordic_phase_sched.sv | 92 +++++++++
 1 files changed

// File: rtl/cordic_phase_sched.sv
// cordic_phase_sched: two-channel phase generator sharing one CORDIC, with credit-limited issue and in-order result demux.
module cordic_phase_sched #(
    parameter int          DEPTH  = 8,
    parameter logic [15:0] PI_POS = 16'h6488,
    parameter logic [15:0] PI_NEG = 16'h9B78
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         ch_en,
    input  logic signed [15:0] inc0,
    input  logic signed [15:0] inc1,
    output logic               m_phase_tvalid,
    output logic signed [15:0] m_phase_tdata,
    input  logic               s_dout_tvalid,
    input  logic [31:0]        s_dout_tdata,
    output logic signed [15:0] sin0,
    output logic signed [15:0] cos0,
    output logic signed [15:0] sin1,
    output logic signed [15:0] cos1,
    output logic               valid0,
    output logic               valid1,
    output logic               busy,
    output logic               err_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    state_t             r_state;
    logic signed [15:0] r_phase0, r_phase1;
    logic [DEPTH-1:0]   r_tags;
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [AW:0]        r_cnt;
    logic               r_rr;
    logic               w_issue, w_sel, w_pop, w_tag;
    logic signed [15:0] w_phase, w_inc;
    logic signed [16:0] w_sum;
    logic [15:0]        w_next;
    assign w_issue = r_state == S_RUN && enable && r_cnt < FULL && |ch_en;
    assign w_sel   = &ch_en ? r_rr : ch_en[1];
    assign w_phase = w_sel ? r_phase1 : r_phase0;
    assign w_inc   = w_sel ? inc1 : inc0;
    // Limit check happens on the 17-bit sum so a carry out of 16 bits still saturates to -pi.
    assign w_sum   = {w_phase[15], w_phase} + {w_inc[15], w_inc};
    assign w_next  = w_sum <= $signed({PI_POS[15], PI_POS}) ? w_sum[15:0] : PI_NEG;
    assign w_pop   = s_dout_tvalid && r_cnt != '0;
    assign w_tag   = r_tags[r_rd_ptr];
    assign busy    = r_state != S_IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_phase0       <= '0;
            r_phase1       <= '0;
            r_tags         <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_cnt          <= '0;
            r_rr           <= 1'b0;
            m_phase_tvalid <= 1'b0;
            m_phase_tdata  <= '0;
            sin0           <= '0;
            cos0           <= '0;
            sin1           <= '0;
            cos1           <= '0;
            valid0         <= 1'b0;
            valid1         <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            r_state <= r_state == S_IDLE ? (enable ? S_RUN : S_IDLE) :
                       r_state == S_RUN  ? (enable ? S_RUN : S_DRAIN) :
                       enable ? S_RUN : (r_cnt == '0 ? S_IDLE : S_DRAIN);
            m_phase_tvalid <= w_issue;
            valid0         <= w_pop && !w_tag;
            valid1         <= w_pop && w_tag;
            if (w_issue) begin
                m_phase_tdata     <= w_phase;
                r_tags[r_wr_ptr]  <= w_sel;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_rr              <= !w_sel;
                if (w_sel) r_phase1 <= w_next;
                else       r_phase0 <= w_next;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_tag) {sin1, cos1} <= s_dout_tdata;
                else       {sin0, cos0} <= s_dout_tdata;
            end
            r_cnt <= r_cnt + {{AW{1'b0}}, w_issue} - {{AW{1'b0}}, w_pop};
            if (s_dout_tvalid && r_cnt == '0) err_overflow <= 1'b1;
        end
    end
endmodule
